// File: rtl/pmp_seq_checker.sv
// Sequential PMP checker: one shared pmp_entry matcher walks the entries in index order.
// Build macro PMP_SEQ_CONST_TIME_EN: always scan every entry, so latency does not depend on the address.
package riscv;
  typedef enum logic [1:0] {
    OFF   = 2'b00,
    TOR   = 2'b01,
    NA4   = 2'b10,
    NAPOT = 2'b11
  } pmp_addr_mode_t;

  typedef struct packed {
    logic x;
    logic w;
    logic r;
  } pmpcfg_access_t;

  typedef struct packed {
    logic           locked;
    logic [1:0]     reserved;
    pmp_addr_mode_t addr_mode;
    pmpcfg_access_t access_type;
  } pmpcfg_t;
endpackage

module pmp_entry #(
  parameter int unsigned PLEN            = 56,
  parameter int unsigned PMP_LEN         = 54,
  parameter int unsigned PMP_GRANULARITY = 0
) (
  input  logic [PLEN-1:0]       addr_i,
  input  logic [PMP_LEN-1:0]    conf_addr_i,
  input  logic [PMP_LEN-1:0]    conf_addr_prev_i,
  input  riscv::pmp_addr_mode_t conf_addr_mode_i,
  output logic                  match_o
);
  localparam int unsigned AW = (PLEN > PMP_LEN + 2) ? PLEN : PMP_LEN + 2;

  // Coarse granularity forces the low NAPOT bits to ones (region never smaller than the grain).
  function automatic logic [PMP_LEN-1:0] gran_ones();
    logic [PMP_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < int'(PMP_LEN); i++)
      if (i + 1 < int'(PMP_GRANULARITY)) m[i] = 1'b1;
    return m;
  endfunction

  localparam logic [PMP_LEN-1:0] GRAN_ONES = gran_ones();

  logic [AW-1:0]      w_addr;
  logic [AW-1:0]      w_top;
  logic [AW-1:0]      w_base;
  logic [AW-1:0]      w_napot_mask;
  logic [PMP_LEN-1:0] w_napot_addr;

  assign w_addr       = AW'(addr_i);
  assign w_top        = AW'({conf_addr_i, 2'b00});
  assign w_base       = AW'({conf_addr_prev_i, 2'b00});
  assign w_napot_addr = conf_addr_i | GRAN_ONES;
  // Trailing ones plus the first zero above them mark the don't-care bits of the region.
  assign w_napot_mask = AW'({w_napot_addr ^ (w_napot_addr + PMP_LEN'(1)), 2'b11});

  always_comb begin
    match_o = 1'b0;
    case (conf_addr_mode_i)
      riscv::TOR:   match_o = (w_addr >= w_base) && (w_addr < w_top);
      riscv::NA4:   match_o = (w_addr[AW-1:2] == w_top[AW-1:2]);
      riscv::NAPOT: match_o = (((w_addr ^ w_top) & ~w_napot_mask) == '0);
      default:      match_o = 1'b0;
    endcase
  end
endmodule

// state  | meaning
// S_IDLE | ready for a request
// S_SCAN | evaluating entry r_idx with the shared matcher
// S_RESP | result held on rsp_* until consumed
module pmp_seq_checker #(
  parameter int unsigned PLEN           = 56,
  parameter int unsigned PMP_LEN        = 54,
  parameter int unsigned NR_ENTRIES     = 16,
  parameter int unsigned PMPGranularity = 0,
  localparam int unsigned IW = (NR_ENTRIES > 1) ? $clog2(NR_ENTRIES) : 1
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 req_valid_i,
  output logic                 req_ready_o,
  input  logic [PLEN-1:0]      req_addr_i,
  input  logic [2:0]           req_type_i,
  input  logic                 req_priv_m_i,
  input  logic [PMP_LEN-1:0]   conf_addr_i [NR_ENTRIES],
  input  riscv::pmpcfg_t       conf_i [NR_ENTRIES],
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_allow_o,
  output logic                 rsp_hit_o,
  output logic [IW-1:0]        rsp_idx_o
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_SCAN = 2'b01,
    S_RESP = 2'b10
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IW-1:0]      r_idx;
  logic [IW-1:0]      w_idx_nxt;
  logic [PLEN-1:0]    r_addr;
  logic [2:0]         r_type;
  logic               r_priv_m;
  logic               r_hit;
  logic               w_hit_nxt;
  logic [IW-1:0]      r_hit_idx;
  logic [IW-1:0]      w_hit_idx_nxt;
  logic               r_allow;
  logic               w_allow_nxt;
  logic               w_capture;
  logic               w_last;
  logic               w_match;
  logic               w_allow_hit;
  riscv::pmpcfg_t     w_cfg;
  logic [PMP_LEN-1:0] w_cur_addr;
  logic [PMP_LEN-1:0] w_prev_addr;
  logic [2:0]         w_perm;
  logic               w_unused_ok;

  // Configuration is read live from the current index every cycle.
  assign w_cfg       = conf_i[r_idx];
  assign w_cur_addr  = conf_addr_i[r_idx];
  assign w_prev_addr = (r_idx == '0) ? '0 : conf_addr_i[r_idx - IW'(1)];
  assign w_perm      = w_cfg.access_type;
  assign w_last      = (r_idx == IW'(NR_ENTRIES - 1));
  assign w_allow_hit = (r_priv_m & ~w_cfg.locked) | ((w_perm & r_type) == r_type);
  assign w_unused_ok = ^w_cfg.reserved;

  pmp_entry #(
    .PLEN            (PLEN),
    .PMP_LEN         (PMP_LEN),
    .PMP_GRANULARITY (PMPGranularity)
  ) u_pmp_entry (
    .addr_i           (r_addr),
    .conf_addr_i      (w_cur_addr),
    .conf_addr_prev_i (w_prev_addr),
    .conf_addr_mode_i (w_cfg.addr_mode),
    .match_o          (w_match)
  );

  always_comb begin
    w_state_nxt   = r_state;
    w_idx_nxt     = r_idx;
    w_hit_nxt     = r_hit;
    w_hit_idx_nxt = r_hit_idx;
    w_allow_nxt   = r_allow;
    w_capture     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (req_valid_i) begin
          w_capture     = 1'b1;
          w_idx_nxt     = '0;
          w_hit_nxt     = 1'b0;
          w_hit_idx_nxt = '0;
          w_allow_nxt   = 1'b0;
          w_state_nxt   = S_SCAN;
        end
      end
      S_SCAN: begin
`ifdef PMP_SEQ_CONST_TIME_EN
        if (w_match && !r_hit) begin
          w_hit_nxt     = 1'b1;
          w_hit_idx_nxt = r_idx;
          w_allow_nxt   = w_allow_hit;
        end
        if (w_last) begin
          if (!r_hit && !w_match) begin
            w_hit_idx_nxt = '0;
            w_allow_nxt   = r_priv_m;
          end
          w_state_nxt = S_RESP;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
`else
        if (w_match) begin
          w_hit_nxt     = 1'b1;
          w_hit_idx_nxt = r_idx;
          w_allow_nxt   = w_allow_hit;
          w_state_nxt   = S_RESP;
        end else if (w_last) begin
          w_hit_nxt     = 1'b0;
          w_hit_idx_nxt = '0;
          w_allow_nxt   = r_priv_m;
          w_state_nxt   = S_RESP;
        end else begin
          w_idx_nxt = r_idx + IW'(1);
        end
`endif
      end
      S_RESP: begin
        if (rsp_ready_i) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_idx     <= '0;
      r_addr    <= '0;
      r_type    <= '0;
      r_priv_m  <= 1'b0;
      r_hit     <= 1'b0;
      r_hit_idx <= '0;
      r_allow   <= 1'b0;
    end else begin
      r_idx     <= w_idx_nxt;
      r_hit     <= w_hit_nxt;
      r_hit_idx <= w_hit_idx_nxt;
      r_allow   <= w_allow_nxt;
      if (w_capture) begin
        r_addr   <= req_addr_i;
        r_type   <= req_type_i;
        r_priv_m <= req_priv_m_i;
      end
    end
  end

  assign req_ready_o = (r_state == S_IDLE);
  assign rsp_valid_o = (r_state == S_RESP);
  assign rsp_allow_o = rsp_valid_o & r_allow;
  assign rsp_hit_o   = rsp_valid_o & r_hit;
  assign rsp_idx_o   = rsp_valid_o ? r_hit_idx : '0;
endmodule
